// File: rtl/tube_p_r3_dma.sv
// Parasite-side tube register-3 block-transfer engine: answers PNMI by moving a
// programmed byte count between tube R3 and a local memory port, either way.
module tube_p_r3_dma #(
   parameter int          ADDR_W  = 16,
   parameter int          LEN_W   = 16,
   parameter logic [2:0]  R3_ADDR = 3'h5,
   parameter int          GAP_CYC = 1
) (
   input  logic              p_phi2,
   input  logic              p_rst_b,
   input  logic              start,
   input  logic              abort,
   input  logic              dir,
   input  logic              two_byte,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic              t_nmi_b,
   output logic              t_cs_b,
   output logic [2:0]        t_addr,
   output logic              t_rdnw,
   output logic [7:0]        t_wdata,
   input  logic [7:0]        t_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done
);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WAIT_NMI = 3'd1;
   localparam logic [2:0] ST_MEM_RD   = 3'd2;
   localparam logic [2:0] ST_T_WR     = 3'd3;
   localparam logic [2:0] ST_T_RD     = 3'd4;
   localparam logic [2:0] ST_MEM_WR   = 3'd5;
   localparam logic [2:0] ST_GAP      = 3'd6;
   localparam logic [2:0] ST_FIN      = 3'd7;

   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   logic [2:0]        state;
   logic              nmi_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  rem_q;
   logic              dir_q;
   logic              two_q;
   logic [1:0]        beat_q;
   logic [GAP_W-1:0]  gap_q;
   logic [7:0]        t_wdata_q;
   logic [7:0]        mem_wdata_q;

   logic              byte_done;
   logic [2:0]        after_byte;

   assign byte_done = (state == ST_T_WR) || ((state == ST_MEM_WR) && mem_ready);

   // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      after_byte = ST_GAP;
      if (rem_q == LEN_W'(1))
         after_byte = ST_FIN;
      else if (beat_q != 2'd1)
         after_byte = dir_q ? ST_MEM_RD : ST_T_RD;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
   always_ff @(posedge p_phi2 or negedge p_rst_b) begin
      if (!p_rst_b) begin
         state       <= ST_IDLE;
         nmi_q       <= 1'b1;
         addr_q      <= '0;
         rem_q       <= '0;
         dir_q       <= 1'b0;
         two_q       <= 1'b0;
         beat_q      <= '0;
         gap_q       <= '0;
         t_wdata_q   <= '0;
         mem_wdata_q <= '0;
      end else begin
         nmi_q <= t_nmi_b;
         if (abort && (state != ST_IDLE)) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: if (start) begin
                  addr_q <= base_addr;
                  rem_q  <= length;
                  dir_q  <= dir;
                  two_q  <= two_byte;
                  state  <= (length == '0) ? ST_FIN : ST_WAIT_NMI;
               end
               ST_WAIT_NMI: if (!nmi_q) begin
                  beat_q <= two_q ? 2'd2 : 2'd1;
                  state  <= dir_q ? ST_MEM_RD : ST_T_RD;
               end
               ST_T_RD: begin
                  mem_wdata_q <= t_rdata;
                  state       <= ST_MEM_WR;
               end
               ST_MEM_RD: if (mem_ready) begin
                  t_wdata_q <= mem_rdata;
                  state     <= ST_T_WR;
               end
               ST_MEM_WR, ST_T_WR: if (byte_done) begin
                  addr_q <= addr_q + 1'b1;
                  rem_q  <= rem_q - 1'b1;
                  beat_q <= beat_q - 2'd1;
                  gap_q  <= GAP_W'(GAP_CYC - 1);
                  state  <= after_byte;
               end
               ST_GAP: begin
                  // Hold the bus idle so the tube NMI flag settles before re-sampling.
                  if (gap_q == '0)
                     state <= ST_WAIT_NMI;
                  else
                     gap_q <= gap_q - 1'b1;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // Strobes decode straight from state so a reset or abort removes them immediately.
   assign t_cs_b    = !((state == ST_T_RD) || (state == ST_T_WR));
   assign t_rdnw    = (state != ST_T_WR);
   assign t_addr    = R3_ADDR;
   assign t_wdata   = t_wdata_q;
   assign mem_addr  = addr_q;
   assign mem_re    = (state == ST_MEM_RD);
   assign mem_we    = (state == ST_MEM_WR);
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state != ST_IDLE) && (state != ST_FIN);
   assign done      = (state == ST_FIN);

endmodule

// File: tb/tb_tube_p_r3_dma.sv
// Scoreboard bench for tube_p_r3_dma: tube and memory models, directed transfers.
module tb_tube_p_r3_dma;

   logic        p_phi2 = 1'b0;
   logic        p_rst_b = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        dir = 1'b0;
   logic        two_byte = 1'b0;
   logic [15:0] base_addr = '0;
   logic [15:0] length = '0;
   logic        t_nmi_b = 1'b1;
   logic        t_cs_b;
   logic [2:0]  t_addr;
   logic        t_rdnw;
   logic [7:0]  t_wdata;
   logic [7:0]  t_rdata;
   logic [15:0] mem_addr;
   logic        mem_re;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ready = 1'b1;
   logic        busy;
   logic        done;

   tube_p_r3_dma dut (
      .p_phi2(p_phi2), .p_rst_b(p_rst_b), .start(start), .abort(abort),
      .dir(dir), .two_byte(two_byte), .base_addr(base_addr), .length(length),
      .t_nmi_b(t_nmi_b), .t_cs_b(t_cs_b), .t_addr(t_addr), .t_rdnw(t_rdnw),
      .t_wdata(t_wdata), .t_rdata(t_rdata), .mem_addr(mem_addr),
      .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .done(done)
   );

   always #5 p_phi2 = ~p_phi2;

   typedef enum logic [1:0] {EV_MEMW, EV_TUBEW, EV_DONE} ev_kind_t;
   typedef struct packed {
      ev_kind_t    kind;
      logic [15:0] addr;
      logic [7:0]  data;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input ev_kind_t k, input logic [15:0] a, input logic [7:0] d);
      exp_q.push_back('{kind: k, addr: a, data: d});
   endtask

   // Memory model: read data from a small table indexed by the low address bits.
   logic [7:0] rd_mem [16];
   assign mem_rdata = rd_mem[mem_addr[3:0]];

   // Tube model: byte source for R3 reads and an NMI that drops per burst.
   logic [7:0] tube_src [16];
   logic [3:0] rd_idx = '0;
   logic [3:0] rd_cur = '0;
   logic       nmi_en = 1'b0;
   int         burst = 1;
   int         acc_cnt = 0;
   int         nmi_gap = 0;
   int         nmi_cnt = 0;
   assign t_rdata = tube_src[rd_cur];

   always @(posedge p_phi2) begin
      #1 rd_cur = rd_idx;
   end

   always @(negedge p_phi2) begin
      if (!t_cs_b && t_rdnw) rd_idx = rd_idx + 4'd1;
      if (!nmi_en) begin
         acc_cnt = 0;
         nmi_gap = 0;
         t_nmi_b = 1'b1;
      end else if (!t_cs_b) begin
         acc_cnt++;
         if (acc_cnt == burst) begin
            acc_cnt = 0;
            t_nmi_b = 1'b1;
            nmi_gap = 3;
         end
      end else if (t_nmi_b) begin
         if (nmi_gap > 0) nmi_gap--;
         else begin
            t_nmi_b = 1'b0;
            nmi_cnt++;
         end
      end
   end

   // Monitor: pops the scoreboard for every memory write, tube write and done.
   int   cs_pulses = 0;
   int   cs_double = 0;
   int   memre_cnt = 0;
   logic cs_prev_low = 1'b0;

   task automatic compare_ev(input ev_kind_t k, input logic [15:0] a, input logic [7:0] d, input string name);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_%s: got addr %0h data %0h expected no event", name, a, d);
      end else begin
         e = exp_q.pop_front();
         check(name, {6'd0, k, a, d}, {6'd0, e.kind, e.addr, e.data});
      end
   endtask

   always @(negedge p_phi2) begin
      if (p_rst_b) begin
         if (mem_we && mem_ready) compare_ev(EV_MEMW, mem_addr, mem_wdata, "memw");
         if (!t_cs_b && !t_rdnw)  compare_ev(EV_TUBEW, 16'h0, t_wdata, "tubew");
         if (done)                compare_ev(EV_DONE, 16'h0, 8'h0, "done");
         if (mem_re) memre_cnt++;
         if (!t_cs_b) begin
            cs_pulses++;
            if (cs_prev_low) cs_double++;
         end
      end
      cs_prev_low = p_rst_b && !t_cs_b;
   end

   task automatic kick(input logic d, input logic tb2, input logic [15:0] base, input logic [15:0] len);
      @(posedge p_phi2);
      #1;
      dir = d;
      two_byte = tb2;
      base_addr = base;
      length = len;
      burst = tb2 ? 2 : 1;
      nmi_en = (len != 16'h0);
      start = 1'b1;
      @(posedge p_phi2);
      #1 start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge p_phi2);
         n++;
      end
      check({name, "_timeout"}, {31'd0, n < budget}, 32'd1);
      nmi_en = 1'b0;
      @(posedge p_phi2);
      #1 check({name, "_sb_empty"}, exp_q.size(), 0);
   endtask

   task automatic reset_checks(input string name);
      check({name, "_ctl"}, {26'd0, t_cs_b, t_rdnw, mem_re, mem_we, busy, done}, 32'b110000);
      check({name, "_data"}, {t_wdata, mem_wdata, mem_addr}, 32'h0);
   endtask

   initial begin
      int cs0, nmi0, re0, n;
      tube_src = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hC1, 8'hD1, 8'hD2,
                   8'hD3, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'h00, 8'h00, 8'h00};
      rd_mem = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      #1 reset_checks("reset_initial");
      check("t_addr", {29'd0, t_addr}, 32'h5);
      #20 p_rst_b = 1'b1;

      // Tube to memory, single-byte bursts.
      push(EV_MEMW, 16'h1000, 8'hA1);
      push(EV_MEMW, 16'h1001, 8'hA2);
      push(EV_MEMW, 16'h1002, 8'hA3);
      push(EV_DONE, 16'h0, 8'h0);
      cs0 = cs_pulses;
      kick(1'b0, 1'b0, 16'h1000, 16'd3);
      wait_idle("t1", 200);
      check("t1_cs_pulses", cs_pulses - cs0, 3);

      // Memory to tube, two-byte bursts.
      push(EV_TUBEW, 16'h0, 8'h55);
      push(EV_TUBEW, 16'h0, 8'h66);
      push(EV_TUBEW, 16'h0, 8'h77);
      push(EV_TUBEW, 16'h0, 8'h88);
      push(EV_DONE, 16'h0, 8'h0);
      cs0 = cs_pulses;
      nmi0 = nmi_cnt;
      kick(1'b1, 1'b1, 16'h2000, 16'd4);
      wait_idle("t2", 200);
      check("t2_nmi_count", nmi_cnt - nmi0, 2);
      check("t2_cs_pulses", cs_pulses - cs0, 4);

      // Zero length: done the cycle after start, no bus activity.
      push(EV_DONE, 16'h0, 8'h0);
      cs0 = cs_pulses;
      re0 = memre_cnt;
      kick(1'b0, 1'b0, 16'h5000, 16'd0);
      check("t3_done_next_cycle", {31'd0, done}, 32'd1);
      check("t3_busy", {31'd0, busy}, 32'd0);
      @(posedge p_phi2);
      #1 check("t3_done_single", {31'd0, done}, 32'd0);
      check("t3_no_cs", cs_pulses - cs0, 0);
      check("t3_no_mem_re", memre_cnt - re0, 0);
      check("t3_sb_empty", exp_q.size(), 0);

      // Address wrap.
      push(EV_MEMW, 16'hFFFF, 8'hB1);
      push(EV_MEMW, 16'h0000, 8'hB2);
      push(EV_DONE, 16'h0, 8'h0);
      kick(1'b0, 1'b0, 16'hFFFF, 16'd2);
      wait_idle("t4", 200);

      // Memory stall during MEM_WR, then abort.
      mem_ready = 1'b0;
      cs0 = cs_pulses;
      kick(1'b0, 1'b0, 16'h3000, 16'd2);
      n = 0;
      while (!mem_we && n < 100) begin
         @(negedge p_phi2);
         n++;
      end
      check("t5_reach_mem_wr", {31'd0, n < 100}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         check("t5_hold", {7'd0, mem_we, mem_addr, mem_wdata}, {7'd0, 1'b1, 16'h3000, 8'hC1});
         @(negedge p_phi2);
      end
      check("t5_cs_pulses", cs_pulses - cs0, 1);
      @(posedge p_phi2);
      #1 abort = 1'b1;
      @(posedge p_phi2);
      #1 abort = 1'b0;
      check("t5_abort_idle", {28'd0, busy, mem_we, done, t_cs_b}, 32'b0001);
      nmi_en = 1'b0;
      mem_ready = 1'b1;
      repeat (5) @(posedge p_phi2);
      #1 check("t5_sb_empty", exp_q.size(), 0);

      // Truncated second burst; a start while busy must not re-latch.
      push(EV_MEMW, 16'h6000, 8'hD1);
      push(EV_MEMW, 16'h6001, 8'hD2);
      push(EV_MEMW, 16'h6002, 8'hD3);
      push(EV_DONE, 16'h0, 8'h0);
      cs0 = cs_pulses;
      nmi0 = nmi_cnt;
      kick(1'b0, 1'b1, 16'h6000, 16'd3);
      repeat (2) @(posedge p_phi2);
      #1;
      base_addr = 16'h7777;
      length = 16'd5;
      start = 1'b1;
      @(posedge p_phi2);
      #1 start = 1'b0;
      wait_idle("t6", 200);
      check("t6_nmi_count", nmi_cnt - nmi0, 2);
      check("t6_cs_pulses", cs_pulses - cs0, 3);

      // Reset in the middle of a two-byte burst.
      push(EV_MEMW, 16'h8000, 8'hE1);
      kick(1'b0, 1'b1, 16'h8000, 16'd4);
      n = 0;
      while (!(mem_we && mem_ready) && n < 100) begin
         @(negedge p_phi2);
         n++;
      end
      check("t6r_first_write", {31'd0, n < 100}, 32'd1);
      @(posedge p_phi2);
      #1 mem_ready = 1'b0;
      n = 0;
      while (!mem_we && n < 100) begin
         @(negedge p_phi2);
         n++;
      end
      check("t6r_second_mem_wr", {31'd0, n < 100}, 32'd1);
      #2 p_rst_b = 1'b0;
      #1 reset_checks("t6r_reset");
      check("t6r_sb_empty", exp_q.size(), 0);
      nmi_en = 1'b0;
      mem_ready = 1'b1;
      repeat (2) @(posedge p_phi2);
      #2 p_rst_b = 1'b1;
      repeat (3) @(posedge p_phi2);

      check("cs_never_consecutive", cs_double, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
